// File: rtl/sme_param.sv
// sme_param: serially loaded string matcher with '.' wildcard and '^'/'$' word anchors.
// One candidate start per SEARCH cycle after a one-cycle setup; result is a one-cycle valid pulse.
module sme_param #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int CHAR_W = 8,
  parameter int IDX_W = $clog2(STR_MAX)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CHAR_W-1:0] chardata,
  input  logic              isstring,
  input  logic              ispattern,
  output logic              valid,
  output logic              match,
  output logic [IDX_W-1:0]  match_index
);
  localparam int SI_W = $clog2(STR_MAX);
  localparam int PI_W = $clog2(PAT_MAX);
  localparam int SL_W = $clog2(STR_MAX + 1);
  localparam int PL_W = $clog2(PAT_MAX + 1);
  localparam int S_W = SL_W + 1;
  localparam logic [CHAR_W-1:0] CH_DOT = CHAR_W'(8'h2E);
  localparam logic [CHAR_W-1:0] CH_HAT = CHAR_W'(8'h5E);
  localparam logic [CHAR_W-1:0] CH_DOL = CHAR_W'(8'h24);
  localparam logic [CHAR_W-1:0] CH_SP = CHAR_W'(8'h20);
  typedef enum logic [2:0] {IDLE, LOAD_STR, LOAD_PAT, SEARCH, DONE} state_t;
  state_t state_q, state_d;
  logic [CHAR_W-1:0] str_q [STR_MAX];
  logic [CHAR_W-1:0] pat_q [PAT_MAX];
  logic [SL_W-1:0] str_len_q, str_len_d;
  logic [PL_W-1:0] pat_len_q, pat_len_d;
  logic [S_W-1:0] s_q, s_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic prep_q, prep_d, prev_s_q, prev_p_q, valid_q, valid_d, match_q, match_d;
  logic str_we, pat_we, str_wr, pat_wr, sa, ea, fits, hit;
  logic [SI_W-1:0] str_wi;
  logic [PI_W-1:0] pat_wi;
  int c_i, s_i, l_i, p_i;

  // A rising isstring/ispattern restarts that buffer at index 0; pattern wins a tie.
  always_comb begin
    pat_we = ispattern && state_q != SEARCH;
    str_we = isstring && !ispattern && state_q != SEARCH;
    pat_wr = pat_we && (!prev_p_q || int'(pat_len_q) < PAT_MAX);
    str_wr = str_we && (!prev_s_q || int'(str_len_q) < STR_MAX);
    pat_wi = prev_p_q ? PI_W'(pat_len_q) : '0;
    str_wi = prev_s_q ? SI_W'(str_len_q) : '0;
    pat_len_d = !pat_we ? pat_len_q : !prev_p_q ? PL_W'(1) : pat_len_q + PL_W'(int'(pat_len_q) < PAT_MAX);
    str_len_d = !str_we ? str_len_q : !prev_s_q ? SL_W'(1) : str_len_q + SL_W'(int'(str_len_q) < STR_MAX);
  end

  always_comb begin
    sa = pat_len_q != '0 && pat_q[0] == CH_HAT;
    ea = pat_len_q != '0 && pat_q[PI_W'(int'(pat_len_q) - 1)] == CH_DOL && !(sa && pat_len_q == PL_W'(1));
    c_i = int'(pat_len_q) - int'(sa) - int'(ea);
    s_i = int'(s_q);
    l_i = int'(str_len_q);
    fits = s_i + c_i <= l_i;
    hit = fits;
    p_i = 0;
    for (int k = 0; k < PAT_MAX; k++) begin
      p_i = k + int'(sa);
      if (k < c_i && p_i < PAT_MAX && s_i + k < STR_MAX && pat_q[PI_W'(p_i)] != CH_DOT &&
          pat_q[PI_W'(p_i)] != str_q[SI_W'(s_i + k)]) hit = 1'b0;
    end
    if (sa && s_i != 0 && str_q[SI_W'(s_i - 1)] != CH_SP) hit = 1'b0;
    if (ea && s_i + c_i != l_i && (s_i + c_i >= STR_MAX || str_q[SI_W'(s_i + c_i)] != CH_SP)) hit = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    s_d = s_q;
    prep_d = 1'b0;
    valid_d = 1'b0;
    match_d = match_q;
    idx_d = idx_q;
    case (state_q)
      IDLE: state_d = ispattern ? LOAD_PAT : isstring ? LOAD_STR : IDLE;
      LOAD_STR: state_d = ispattern ? LOAD_PAT : LOAD_STR;
      LOAD_PAT: if (!ispattern) begin
        state_d = SEARCH;
        s_d = '0;
        prep_d = 1'b1;
      end
      SEARCH: if (!prep_q) begin
        if (!fits || hit) begin
          state_d = DONE;
          valid_d = 1'b1;
          match_d = hit;
          idx_d = !hit ? '0 : s_i > (1 << IDX_W) - 1 ? '1 : IDX_W'(s_q);
        end else s_d = s_q + S_W'(1);
      end
      DONE: state_d = ispattern ? LOAD_PAT : isstring ? LOAD_STR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (pat_wr) pat_q[pat_wi] <= chardata;
    if (str_wr) str_q[str_wi] <= chardata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      str_len_q <= '0;
      pat_len_q <= '0;
      s_q <= '0;
      idx_q <= '0;
      prep_q <= 1'b0;
      prev_s_q <= 1'b0;
      prev_p_q <= 1'b0;
      valid_q <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      str_len_q <= str_len_d;
      pat_len_q <= pat_len_d;
      s_q <= s_d;
      idx_q <= idx_d;
      prep_q <= prep_d;
      prev_s_q <= isstring;
      prev_p_q <= ispattern;
      valid_q <= valid_d;
      match_q <= match_d;
    end
  end

  assign valid = valid_q;
  assign match = match_q;
  assign match_index = idx_q;
endmodule

// File: tb/tb_sme_param.sv
// tb_sme_param: random and directed string/pattern loads checked every cycle against a
// behavioural matcher that scans start positions over byte queues.
module tb_sme_param;
  typedef logic [7:0] bq_t[$];
  logic clk = 1'b0, reset = 1'b1, isstring = 1'b0, ispattern = 1'b0;
  logic [7:0] chardata = 8'h00;
  logic valid, match;
  logic [4:0] match_index;
  int cyc = 0, exp_cyc = -1, n_cmp = 0, n_err = 0, ei = 0, cur_i = 0;
  logic em = 1'b0, cur_m = 1'b0, exp_v;
  bq_t mstr, mpat;

  sme_param dut (
    .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
    .valid(valid), .match(match), .match_index(match_index)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Outputs hold between results; valid only on the cycle the model says the result lands.
  always @(negedge clk) begin
    exp_v = (cyc == exp_cyc);
    if (exp_v) begin
      cur_m = em;
      cur_i = ei;
    end
    chk("valid", valid, exp_v);
    chk("match", match, cur_m);
    chk("match_index", match_index, cur_i);
  end

  function automatic bq_t s2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // mode 0: string, 1: pattern, 2: both strobes high (pattern only)
  task automatic send(input int mode, input bq_t q);
    for (int i = 0; i < q.size(); i++) begin
      chardata = q[i];
      isstring = (mode != 1);
      ispattern = (mode != 0);
      @(negedge clk);
    end
    isstring = 1'b0;
    ispattern = 1'b0;
    if (mode == 0) begin
      mstr = {};
      foreach (q[i]) if (mstr.size() < 32) mstr.push_back(q[i]);
    end else begin
      mpat = {};
      foreach (q[i]) if (mpat.size() < 8) mpat.push_back(q[i]);
    end
  endtask

  function automatic void model(output logic m, output int idx, output int lat);
    int l, p, c, off;
    logic sa, ea, ok;
    l = mstr.size();
    p = mpat.size();
    sa = p > 0 && mpat[0] == 8'h5E;
    ea = p > 0 && mpat[p-1] == 8'h24 && !(sa && p == 1);
    off = sa ? 1 : 0;
    c = p - off - (ea ? 1 : 0);
    for (int s = 0; s <= 64; s++) begin
      if (s + c > l) begin
        m = 1'b0; idx = 0; lat = s + 2;
        return;
      end
      ok = 1'b1;
      for (int k = 0; k < c; k++)
        if (mpat[off+k] != 8'h2E && mpat[off+k] != mstr[s+k]) ok = 1'b0;
      if (sa && s != 0 && mstr[s-1] != 8'h20) ok = 1'b0;
      if (ea && s + c != l && mstr[s+c] != 8'h20) ok = 1'b0;
      if (ok) begin
        m = 1'b1; idx = (s > 31) ? 31 : s; lat = s + 2;
        return;
      end
    end
    m = 1'b0; idx = 0; lat = 0;
  endfunction

  task automatic pat(input bq_t q, input int mode, output logic m, output int idx, output int lat);
    send(mode, q);
    model(m, idx, lat);
    em = m;
    ei = idx;
    exp_cyc = cyc + 1 + lat;
    while (cyc < exp_cyc) @(negedge clk);
  endtask

  task automatic pin(input string p, input int mode, input logic m, input int i, input int l);
    logic gm;
    int gi, gl;
    pat(s2q(p), mode, gm, gi, gl);
    chk({"model_match ", p}, gm, m);
    chk({"model_index ", p}, gi, i);
    chk({"model_latency ", p}, gl, l);
  endtask

  initial begin
    int base, n;
    logic rm;
    int ri, rl;
    bq_t q;
    string alpha_s, alpha_p;
    alpha_s = "ab c";
    alpha_p = "ab.c ";
    repeat (3) @(negedge clk);
    reset = 1'b0;
    send(0, s2q("the cat sat"));
    pin("cat", 1, 1'b1, 4, 6);
    pin("^sat", 1, 1'b1, 8, 10);
    pin("at$", 1, 1'b1, 5, 7);
    pin("^c.t$", 1, 1'b1, 4, 6);
    pin("dog", 1, 1'b0, 0, 11);
    pin("cats", 1, 1'b0, 0, 10);
    pin("sat", 2, 1'b1, 8, 10);
    // abort a search in progress while candidate s=3 is being evaluated
    send(1, s2q("zzz"));
    base = cyc + 1;
    while (cyc < base + 4) @(negedge clk);
    #2 reset = 1'b1;
    mstr = {}; mpat = {}; cur_m = 1'b0; cur_i = 0; exp_cyc = -1;
    #1;
    chk("reset_valid", valid, 1'b0);
    chk("reset_match", match, 1'b0);
    chk("reset_index", match_index, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    send(0, s2q("a cat"));
    pin("cat", 1, 1'b1, 2, 4);
    send(0, s2q("abcdefghijklmnopqrstuvwxyzabcdefghijklmn"));
    pin("$", 1, 1'b1, 31, 34);
    pin(".................................", 1, 1'b1, 0, 2);
    for (int it = 0; it < 40; it++) begin
      if (it == 0 || $urandom_range(2) == 0) begin
        q = {};
        n = $urandom_range(40, 1);
        for (int i = 0; i < n; i++) q.push_back(alpha_s[$urandom_range(3)]);
        send(0, q);
      end
      repeat ($urandom_range(3, 1)) begin
        q = {};
        if ($urandom_range(1) == 1) q.push_back(8'h5E);
        n = $urandom_range(6);
        for (int i = 0; i < n; i++) q.push_back(alpha_p[$urandom_range(4)]);
        if ($urandom_range(1) == 1) q.push_back(8'h24);
        if (q.size() == 0) q.push_back(8'h61);
        pat(q, 1, rm, ri, rl);
      end
    end
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5000000;
    n_err++;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end
endmodule
